fetch_issue_queue: RTL

//  Instruction queue between the dual-fetch stage and the dual-issue decode stage.

---
 rtl/fetch_issue_queue.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_issue_queue.sv
// In-order instruction queue between dual fetch and dual-issue decode: up to two pushes
// and two pops per cycle, flush on redirect. Optional stall counter under FIQ_STATS_EN.
module fetch_issue_queue #(
   parameter int DEPTH = 8,
   parameter int IW    = 32,
   parameter int AW    = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid1,
   input  logic                    in_valid2,
   input  logic [AW-1:0]           in_pc,
   input  logic [IW-1:0]           in_instr1,
   input  logic [IW-1:0]           in_instr2,
   output logic                    hold,
   output logic                    out_valid1,
   output logic                    out_valid2,
   output logic [IW-1:0]           out_instr1,
   output logic [IW-1:0]           out_instr2,
   output logic [AW-1:0]           out_pc1,
   output logic [AW-1:0]           out_pc2,
   input  logic                    accept1,
   input  logic                    accept2,
   output logic [$clog2(DEPTH):0]  count
`ifdef FIQ_STATS_EN
   ,
   output logic [15:0]             stall_cycles
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   // Pointers are PW bits wide, so the add wraps modulo DEPTH for free.
   function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
      return p + ptr_t'(n);
   endfunction

   logic [AW-1:0] pc_mem_r    [DEPTH];
   logic [IW-1:0] instr_mem_r [DEPTH];
   ptr_t          rd_ptr_r;
   ptr_t          wr_ptr_r;
   cnt_t          count_r;

   logic          hold_s;
   logic          valid1_s;
   logic          valid2_s;
   logic          push1_s;
   logic          push2_s;
   logic          pop1_s;
   logic          pop2_s;
   logic [1:0]    push_n_s;
   logic [1:0]    pop_n_s;
   cnt_t          count_next_s;
   ptr_t          rd_ptr1_s;
   ptr_t          wr_ptr1_s;

   // Occupancy-derived flags plus push/pop decisions for this cycle.
   always_comb begin
      hold_s       = 1'b0;
      valid1_s     = 1'b0;
      valid2_s     = 1'b0;
      push1_s      = 1'b0;
      push2_s      = 1'b0;
      pop1_s       = 1'b0;
      pop2_s       = 1'b0;
      push_n_s     = 2'd0;
      pop_n_s      = 2'd0;
      count_next_s = count_r;
      rd_ptr1_s    = ptr_add(rd_ptr_r, 2'd1);
      wr_ptr1_s    = ptr_add(wr_ptr_r, 2'd1);

      // Fewer than two free slots: refuse any push, regardless of same-cycle pops.
      if (count_r > cnt_t'(DEPTH - 2)) begin
         hold_s = 1'b1;
      end else begin
         hold_s = 1'b0;
      end

      if (count_r >= cnt_t'(1)) begin
         valid1_s = 1'b1;
      end else begin
         valid1_s = 1'b0;
      end

      if (count_r >= cnt_t'(2)) begin
         valid2_s = 1'b1;
      end else begin
         valid2_s = 1'b0;
      end

      if (!hold_s && in_valid1) begin
         push1_s = 1'b1;
         push2_s = in_valid2;
      end else begin
         push1_s = 1'b0;
         push2_s = 1'b0;
      end

      if (accept1 && valid1_s) begin
         pop1_s = 1'b1;
         pop2_s = accept2 && valid2_s;
      end else begin
         pop1_s = 1'b0;
         pop2_s = 1'b0;
      end

      push_n_s     = {1'b0, push1_s} + {1'b0, push2_s};
      pop_n_s      = {1'b0, pop1_s} + {1'b0, pop2_s};
      count_next_s = count_r + cnt_t'(push_n_s) - cnt_t'(pop_n_s);
   end

   // Head and head+1 presentation; payload is forced to zero when the slot is empty.
   always_comb begin
      out_valid1 = valid1_s;
      out_valid2 = valid2_s;
      hold       = hold_s;
      count      = count_r;
      if (valid1_s) begin
         out_instr1 = instr_mem_r[rd_ptr_r];
         out_pc1    = pc_mem_r[rd_ptr_r];
      end else begin
         out_instr1 = {IW{1'b0}};
         out_pc1    = {AW{1'b0}};
      end
      if (valid2_s) begin
         out_instr2 = instr_mem_r[rd_ptr1_s];
         out_pc2    = pc_mem_r[rd_ptr1_s];
      end else begin
         out_instr2 = {IW{1'b0}};
         out_pc2    = {AW{1'b0}};
      end
   end

   // Pointer and occupancy registers; reset beats flush, flush beats traffic.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_r <= ptr_t'(0);
         wr_ptr_r <= ptr_t'(0);
         count_r  <= cnt_t'(0);
      end else if (flush) begin
         rd_ptr_r <= ptr_t'(0);
         wr_ptr_r <= ptr_t'(0);
         count_r  <= cnt_t'(0);
      end else begin
         rd_ptr_r <= ptr_add(rd_ptr_r, pop_n_s);
         wr_ptr_r <= ptr_add(wr_ptr_r, push_n_s);
         count_r  <= count_next_s;
      end
   end

   // Entry storage; contents need no reset because validity comes from count_r alone.
   always_ff @(posedge clk) begin
      if (rst && !flush && push1_s) begin
         pc_mem_r[wr_ptr_r]    <= in_pc;
         instr_mem_r[wr_ptr_r] <= in_instr1;
      end
      if (rst && !flush && push2_s) begin
         pc_mem_r[wr_ptr1_s]    <= in_pc + AW'(1'b1);
         instr_mem_r[wr_ptr1_s] <= in_instr2;
      end
   end

`ifdef FIQ_STATS_EN
   logic [15:0] stall_cycles_r;

   // Saturating count of cycles where fetch had work but was held off; survives flush.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cycles_r <= 16'd0;
      end else if (hold_s && in_valid1 && (stall_cycles_r != 16'hFFFF)) begin
         stall_cycles_r <= stall_cycles_r + 16'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign stall_cycles = stall_cycles_r;
`endif

endmodule
